// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the nibble-serial RAM bus: op encoding, opcode nibbles,
// frame slot indices and controller FSM states.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_WRM = 2'd0,
        OP_WRS = 2'd1,
        OP_RDM = 2'd2,
        OP_RDS = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SRC  = 2'd2,
        ST_IO   = 2'd3
    } state_e;

    // Frame slot indices within the 8-cycle frame
    localparam logic [2:0] SLOT_OPC  = 3'd4;
    localparam logic [2:0] SLOT_XFER = 3'd6;
    localparam logic [2:0] SLOT_LAST = 3'd7;

    localparam logic [3:0] OPC_WRM    = 4'h0;
    localparam logic [3:0] OPC_RDM    = 4'h9;
    localparam logic [1:0] OPC_WRS_HI = 2'b01;
    localparam logic [1:0] OPC_RDS_HI = 2'b11;

    typedef struct packed {
        logic       chip;
        logic [1:0] rreg;
        logic [3:0] chr;
    } addr_t;

    typedef struct packed {
        op_e        op;
        addr_t      addr;
        logic [1:0] sidx;
        logic [3:0] wdata;
    } req_t;

    function automatic logic [3:0] opcode(input op_e op, input logic [1:0] sidx);
        logic [3:0] opc;
        case (op)
            OP_WRM:  opc = OPC_WRM;
            OP_WRS:  opc = {OPC_WRS_HI, sidx};
            OP_RDM:  opc = OPC_RDM;
            default: opc = {OPC_RDS_HI, sidx};
        endcase
        return opc;
    endfunction

    function automatic logic is_read(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/bus_cycle_timer.sv
// Free-running 0..7 frame cycle counter shared by the controller and RAM models.
module bus_cycle_timer
    import ram_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    output logic [2:0] cycle,
    output logic       last_cycle
);

    logic [2:0] cycle_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= 3'd0;
        end else begin
            cycle_q <= cycle_q + 3'd1;
        end
    end

    assign cycle      = cycle_q;
    assign last_cycle = (cycle_q == SLOT_LAST);

endmodule

// File: rtl/ram_ctrl.sv
// RAM bus controller: sends an optional SRC address frame then an IO frame per
// request, skipping SRC when the address matches the last one sent.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_CACHE = 1
) (
    input  logic       clock,
    input  logic       reset,
    inout  wire  [3:0] data,
    output logic       sync,
    output logic       cmd_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic       req_chip,
    input  logic [1:0] req_reg,
    input  logic [3:0] req_char,
    input  logic [1:0] req_sidx,
    input  logic [3:0] req_wdata,
    output logic       rsp_valid,
    output logic [3:0] rsp_data
);

    logic [2:0] cycle;
    logic       last_cycle;
    logic [2:0] cycle_nx;

    state_e     state_q, state_d, frame_st;
    req_t       req_q, req_d, req_in;
    addr_t      cache_q;
    logic       cache_vld_q;
    logic       handshake, hit, capture;

    logic       drive_q, drive_d;
    logic [3:0] dout_q, dout_d;
    logic       cmd_n_q, cmd_n_d;
    logic       sync_q;
    logic       rsp_valid_q;
    logic [3:0] rsp_data_q;

    bus_cycle_timer u_timer (
        .clock      (clock),
        .reset      (reset),
        .cycle      (cycle),
        .last_cycle (last_cycle)
    );

    assign cycle_nx  = cycle + 3'd1;
    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign handshake = req_valid && req_ready;

    always_comb begin
        req_in            = '0;
        req_in.op         = op_e'(req_op);
        req_in.addr.chip  = req_chip;
        req_in.addr.rreg  = req_reg;
        req_in.addr.chr   = req_char;
        req_in.sidx       = req_sidx;
        req_in.wdata      = req_wdata;
    end

    assign req_d    = handshake ? req_in : req_q;
    assign hit      = (ADDR_CACHE != 0) && cache_vld_q && (req_d.addr == cache_q);
    assign frame_st = hit ? ST_IO : ST_SRC;
    assign capture  = (state_q == ST_IO) && (cycle == SLOT_XFER);

    // Frames only change on the last-cycle edge so a frame is never split.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (handshake)  state_d = last_cycle ? frame_st : ST_WAIT;
            ST_WAIT: if (last_cycle) state_d = frame_st;
            ST_SRC:  if (last_cycle) state_d = ST_IO;
            ST_IO:   if (last_cycle) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus slot values for the upcoming cycle, registered so pins change cleanly.
    always_comb begin
        drive_d = 1'b0;
        dout_d  = 4'h0;
        cmd_n_d = 1'b1;
        if (state_d == ST_SRC) begin
            if (cycle_nx == SLOT_XFER) begin
                drive_d = 1'b1;
                dout_d  = {1'b0, req_d.addr.chip, req_d.addr.rreg};
                cmd_n_d = 1'b0;
            end else if (cycle_nx == SLOT_LAST) begin
                drive_d = 1'b1;
                dout_d  = req_d.addr.chr;
            end
        end else if (state_d == ST_IO) begin
            if (cycle_nx == SLOT_OPC) begin
                drive_d = 1'b1;
                dout_d  = opcode(req_d.op, req_d.sidx);
                cmd_n_d = 1'b0;
            end else if (cycle_nx == SLOT_XFER && !is_read(req_d.op)) begin
                drive_d = 1'b1;
                dout_d  = req_d.wdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            cache_q     <= '0;
            cache_vld_q <= 1'b0;
            drive_q     <= 1'b0;
            dout_q      <= 4'h0;
            cmd_n_q     <= 1'b1;
            sync_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            if (state_q == ST_SRC && last_cycle) begin
                cache_q     <= req_q.addr;
                cache_vld_q <= 1'b1;
            end
            drive_q     <= drive_d;
            dout_q      <= dout_d;
            cmd_n_q     <= cmd_n_d;
            sync_q      <= (cycle_nx == SLOT_LAST);
            rsp_valid_q <= capture;
            if (capture) begin
                rsp_data_q <= is_read(req_q.op) ? data : 4'h0;
            end
        end
    end

    assign data      = drive_q ? dout_q : 4'hz;
    assign cmd_n     = cmd_n_q;
    assign sync      = sync_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: behavioural RAM pair on the bus plus a frame-slot/latency
// reference model; directed cases then randomized traffic.
module tb_ram_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    wire  [3:0] data;
    logic       sync, cmd_n, req_ready, rsp_valid;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'd0;
    logic       req_chip = 1'b0;
    logic [1:0] req_reg = 2'd0;
    logic [3:0] req_char = 4'd0;
    logic [1:0] req_sidx = 2'd0;
    logic [3:0] req_wdata = 4'd0;
    logic [3:0] rsp_data;

    always #5 clock = ~clock;

    ram_ctrl #(.ADDR_CACHE(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .data      (data),
        .sync      (sync),
        .cmd_n     (cmd_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_chip  (req_chip),
        .req_reg   (req_reg),
        .req_char  (req_char),
        .req_sidx  (req_sidx),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    // Bench's own view of the frame cycle
    logic [2:0] tb_cyc = 3'd0;
    always @(posedge clock) tb_cyc <= reset ? 3'd0 : tb_cyc + 3'd1;

    // Two RAM devices (p0=0, p0=1) folded into one model indexed by chip
    logic [3:0] dmem  [0:1][0:63] = '{default: '0};
    logic [3:0] dstat [0:1][0:15] = '{default: '0};
    logic       a_chip = 1'b0;
    logic [1:0] a_reg = 2'd0;
    logic [3:0] a_char = 4'd0, a_op = 4'd0, ram_val = 4'd0;
    logic       src_pend = 1'b0, io_pend = 1'b0, ram_drv = 1'b0;

    assign data = ram_drv ? ram_val : 4'hz;

    always @(posedge clock) begin
        if (reset) begin
            src_pend <= 1'b0;
            io_pend  <= 1'b0;
            ram_drv  <= 1'b0;
        end else begin
            ram_drv <= 1'b0;
            if (tb_cyc == 3'd6 && !cmd_n) begin
                a_chip <= data[2]; a_reg <= data[1:0]; src_pend <= 1'b1;
            end
            if (tb_cyc == 3'd7 && src_pend) begin
                a_char <= data; src_pend <= 1'b0;
            end
            if (tb_cyc == 3'd4 && !cmd_n) begin
                a_op <= data; io_pend <= 1'b1;
            end
            if (tb_cyc == 3'd5 && io_pend && a_op[3]) begin
                ram_drv <= 1'b1;
                ram_val <= a_op[2] ? dstat[a_chip][{a_reg, a_op[1:0]}] : dmem[a_chip][{a_reg, a_char}];
            end
            if (tb_cyc == 3'd6 && io_pend) begin
                io_pend <= 1'b0;
                if (!a_op[3]) begin
                    if (a_op[2]) dstat[a_chip][{a_reg, a_op[1:0]}] <= data;
                    else         dmem[a_chip][{a_reg, a_char}]     <= data;
                end
            end
        end
    end

    int rsp_cnt = 0;
    always @(posedge clock) if (!reset && rsp_valid) rsp_cnt <= rsp_cnt + 1;

    // Reference model state
    logic [3:0] smem  [0:1][0:63] = '{default: '0};
    logic [3:0] sstat [0:1][0:15] = '{default: '0};
    bit         m_cvld = 1'b0;
    logic [6:0] m_caddr = 7'd0;
    int         n_chk = 0, n_pass = 0, exp_rsp = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic wait_cyc(input logic [2:0] c);
        for (int i = 0; i < 8 && tb_cyc != c; i++) @(negedge clock);
    endtask

    // Called at a negedge; rst_k>0 asserts reset at that clock of the transaction.
    task automatic do_req(input logic [1:0] op, input logic chip, input logic [1:0] rg,
                          input logic [3:0] ch, input logic [1:0] sx, input logic [3:0] wd,
                          input bit keep, input int rst_k);
        int n, hcyc, base, lat;
        bit miss;
        logic [3:0] exp_d, opc;
        req_op = op; req_chip = chip; req_reg = rg; req_char = ch;
        req_sidx = sx; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready) begin
            if (n == 40) begin
                chk("rdy_timeout", 8'(req_ready), 8'd1);
                req_valid = 1'b0;
                return;
            end
            @(negedge clock);
            n++;
        end
        hcyc = int'(tb_cyc);
        miss = !(m_cvld && m_caddr == {chip, rg, ch});
        m_cvld = 1'b1;
        m_caddr = {chip, rg, ch};
        base = 7 - hcyc;
        lat = base + (miss ? 16 : 8);
        case (op)
            2'd0: begin opc = 4'h0;        exp_d = 4'h0; smem[chip][{rg, ch}] = wd; end
            2'd1: begin opc = {2'b01, sx}; exp_d = 4'h0; sstat[chip][{rg, sx}] = wd; end
            2'd2: begin opc = 4'h9;        exp_d = smem[chip][{rg, ch}]; end
            default: begin opc = {2'b11, sx}; exp_d = sstat[chip][{rg, sx}]; end
        endcase
        @(negedge clock);
        if (!keep) req_valid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            int pos, c, f;
            bit s, io;
            pos = k - base;
            chk("sync", 8'(sync), 8'(tb_cyc == 3'd7));
            chk("rdy_busy", 8'(req_ready), 8'd0);
            chk("rsp_valid", 8'(rsp_valid), 8'(k == lat));
            if (pos >= 1) begin
                c = (pos - 1) % 8;
                f = (pos - 1) / 8;
                s = miss && f == 0;
                io = miss ? (f == 1) : (f == 0);
                chk("cmd_n", 8'(cmd_n), 8'(!((s && c == 6) || (io && c == 4))));
                if (s && c == 6) chk("src_addr", 8'(data), 8'({1'b0, chip, rg}));
                if (s && c == 7) chk("src_char", 8'(data), 8'(ch));
                if (io && c == 4) chk("opcode", 8'(data), 8'(opc));
                if (io && c == 6 && !op[1]) chk("wdata", 8'(data), 8'(wd));
            end else begin
                chk("cmd_n_wait", 8'(cmd_n), 8'd1);
            end
            if (k == lat) chk("rsp_data", 8'(rsp_data), 8'(exp_d));
            if (k == rst_k) begin
                reset = 1'b1;
                m_cvld = 1'b0;
                return;
            end
            if (k < lat) @(negedge clock);
        end
        exp_rsp++;
        @(negedge clock);
        chk("rdy_after", 8'(req_ready), 8'd1);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_sync", 8'(sync), 8'd0);
        chk("rst_cmd_n", 8'(cmd_n), 8'd1);
        chk("rst_rsp_v", 8'(rsp_valid), 8'd0);
        chk("rst_rsp_d", 8'(rsp_data), 8'd0);
        reset = 1'b0;
        #1;
        chk("rst_rdy", 8'(req_ready), 8'd1);
        @(negedge clock);

        // Write then hit-read, both aligned to a frame boundary
        wait_cyc(3'd7);
        do_req(2'd0, 1'b0, 2'd2, 4'd5, 2'd0, 4'hA, 1'b0, 0);
        chk("ram_word37", 8'(dmem[0][37]), 8'h0A);
        wait_cyc(3'd7);
        do_req(2'd2, 1'b0, 2'd2, 4'd5, 2'd0, 4'h0, 1'b0, 0);

        // Status write/read
        do_req(2'd1, 1'b0, 2'd1, 4'd0, 2'd3, 4'h7, 1'b0, 0);
        do_req(2'd3, 1'b0, 2'd1, 4'd0, 2'd3, 4'h0, 1'b0, 0);

        // Two chips, each change forces SRC
        do_req(2'd0, 1'b0, 2'd0, 4'd0, 2'd0, 4'h3, 1'b0, 0);
        do_req(2'd0, 1'b1, 2'd0, 4'd0, 2'd0, 4'hC, 1'b0, 0);
        do_req(2'd2, 1'b0, 2'd0, 4'd0, 2'd0, 4'h0, 1'b0, 0);
        do_req(2'd2, 1'b1, 2'd0, 4'd0, 2'd0, 4'h0, 1'b0, 0);

        // req_valid held high across back-to-back transactions
        do_req(2'd2, 1'b1, 2'd0, 4'd0, 2'd0, 4'h0, 1'b1, 0);
        do_req(2'd3, 1'b0, 2'd1, 4'd0, 2'd3, 4'h0, 1'b1, 0);
        do_req(2'd2, 1'b0, 2'd2, 4'd5, 2'd0, 4'h0, 1'b0, 0);

        // Reset during IO cycle 5 of a miss read
        wait_cyc(3'd7);
        do_req(2'd2, 1'b1, 2'd0, 4'd0, 2'd0, 4'h0, 1'b0, 14);
        @(negedge clock);
        chk("abort_cmd_n", 8'(cmd_n), 8'd1);
        chk("abort_rsp_v", 8'(rsp_valid), 8'd0);
        chk("abort_sync", 8'(sync), 8'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (20) begin
            @(negedge clock);
            chk("abort_no_rsp", 8'(rsp_valid), 8'd0);
        end
        do_req(2'd2, 1'b1, 2'd0, 4'd0, 2'd0, 4'h0, 1'b0, 0);

        // Randomized traffic over a small address space to mix hits and misses
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op, rg, sx;
            logic       chip;
            logic [3:0] ch, wd;
            op   = 2'($urandom_range(0, 3));
            chip = 1'($urandom_range(0, 1));
            rg   = 2'($urandom_range(0, 1));
            ch   = 4'($urandom_range(0, 1));
            sx   = 2'($urandom_range(0, 3));
            wd   = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 9)) @(negedge clock);
            do_req(op, chip, rg, ch, sx, wd, 1'b0, 0);
        end

        repeat (4) @(negedge clock);
        chk("rsp_count", 8'(rsp_cnt), 8'(exp_rsp));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter ADDR_CACHE, default 1, meaning: 1 enables skipping the SRC frame when the target address matches the last SRC sent; 0 sends SRC on every request.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 data  inout  4  shared RAM bus; driven only in the slots named below, 4'hz otherwise.
REQ-005 sync  output  1  frame marker; high during cycle 7 of every frame.
REQ-006 cmd_n  output  1  active-low command strobe to the RAM devices.
REQ-007 req_valid  input  1  requester has a transaction pending.
REQ-008 req_ready  output  1  controller accepts a transaction this clock.
REQ-009 req_op  input  2  operation: 0 write memory (WRM), 1 write status (WRS), 2 read memory (RDM), 3 read status (RDS).
REQ-010 req_chip  input  1  chip select, compared by the RAM against its p0 strap.
REQ-011 req_reg  input  2  register address.
REQ-012 req_char  input  4  character address.
REQ-013 req_sidx  input  2  status nibble index; used by WRS/RDS only.
REQ-014 req_wdata  input  4  write data; used by WRM/WRS only.
REQ-015 rsp_valid  output  1  one-clock completion pulse.
REQ-016 rsp_data  output  4  read data; 4'h0 for write operations.

Function
REQ-017 A free-running 3-bit cycle counter SHALL run 0..7 and wrap, matching the RAM's counter; every frame spans cycles 0 to 7.
REQ-018 FSM states SHALL be IDLE, WAIT, SRC and IO; all frame transitions occur on the cycle-7 edge.
REQ-019 req_ready SHALL be 1 only in IDLE; a handshake is req_valid and req_ready in the same clock, and it latches all req_* fields.
REQ-020 Next state on handshake: at a cycle-7 edge, go directly to SRC, or to IO on a cache hit; otherwise go to WAIT.
REQ-021 WAIT SHALL move to SRC or IO at the next cycle-7 edge; SRC -> IO and IO -> IDLE at the cycle-7 edge.
REQ-022 Cache hit means ADDR_CACHE=1, cache valid, and latched chip, reg and char equal the cached values.
REQ-023 SRC frame, cycle 6: drive data={1'b0,chip,reg} with cmd_n=0.
REQ-024 SRC frame, cycle 7: drive data=char with cmd_n=1; on this edge load chip/reg/char into the cache and set it valid.
REQ-025 SRC frame, all other cycles: cmd_n=1 and data=4'hz.
REQ-026 IO frame, cycle 4: drive the opcode nibble with cmd_n=0; opcodes are WRM 4'h0, WRS {2'b01,sidx}, RDM 4'h9, RDS {2'b11,sidx}.
REQ-027 IO frame, cycle 6: cmd_n=1; for WRM/WRS drive data=wdata; for RDM/RDS leave data 4'hz and capture data on the cycle-6 edge.
REQ-028 cmd_n SHALL never be low in cycle 6 of an IO frame or in cycle 4 of an SRC frame.
REQ-029 rsp_valid SHALL pulse during cycle 7 of the IO frame, with rsp_data holding the captured nibble (reads) or 4'h0 (writes); rsp_data holds its value until the next pulse.
REQ-030 Latency from handshake at a cycle-7 edge to rsp_valid: 16 clocks on a miss, 8 clocks on a hit.
REQ-031 A request held while busy SHALL be ignored until IDLE, with no loss or duplication.
REQ-032 The controller SHALL never drive data while the RAM drives it (IO frame, cycle 6, read ops).

Reset
REQ-033 On reset: cycle=0, state=IDLE, cache invalid, data=4'hz, cmd_n=1, sync=0, rsp_valid=0, rsp_data=0, req_ready=1 after release.
REQ-034 Reset mid-frame SHALL abort the transaction: no rsp_valid, and the next request always issues SRC.

Structure
REQ-035 A shared package SHALL hold the op encoding, the opcode nibbles, the cycle slot indices (4, 6, 7) and the FSM state enum.
REQ-036 The cycle counter SHALL be a sub-module, bus_cycle_timer, with outputs cycle[2:0] and a last-cycle flag, so RAM models can reuse it.

Verification
REQ-037 Reset, then WRM chip0 reg2 char5 wdata A (RAM p0=0) -> SRC cycle 6 data=2 with cmd_n=0; cycle 7 data=5; IO cycle 4 data=0 with cmd_n=0; cycle 6 data=A; RAM word 37=A; rsp_valid at clock 16.
REQ-038 Then RDM with the same address -> no SRC frame; IO cycle 4 data=9; rsp_valid after 8 clocks with rsp_data=A.
REQ-039 WRS reg1 char0 sidx3 data 7, then RDS sidx3 -> opcodes 7 then F; rsp_data=7.
REQ-040 Two RAMs (p0=0, p0=1): WRM chip0 reg0 char0=3, WRM chip1 reg0 char0=C, read each -> 3 and C; every chip change issues SRC.
REQ-041 Reset asserted at IO cycle 5 -> cmd_n=1 and data=4'hz next clock, no rsp_valid; the next RDM issues SRC.
REQ-042 req_valid held high through a transaction -> req_ready=0 until the clock after rsp_valid; exactly one response per handshake.
